// File: rtl/mfm_write_encoder_if.sv
`default_nettype none
// ============================================================================
// Interface : mfm_write_encoder_if
// Summary   : Word stream from the sector write sequencer into the MFM write
//             encoder (valid/ready handshake with a last-word marker).
// Revision  : 1.0
// ============================================================================
interface mfm_write_encoder_if;
   logic [15:0] word_in;
   logic        word_valid;
   logic        word_last;
   logic        word_ready;

   modport master (
      output word_in,
      output word_valid,
      output word_last,
      input  word_ready
   );

   modport slave (
      input  word_in,
      input  word_valid,
      input  word_last,
      output word_ready
   );
endinterface
`default_nettype wire

// File: rtl/mfm_write_encoder.sv
`default_nettype none
// ============================================================================
// Module   : mfm_write_encoder
// Summary  : Serializes 16-bit words into an MFM write stream (preamble, sync,
//            data, postamble) and drives RL02 write data and write gate.
//            Define MFM_WRITE_CRC_EN to append a CRC-16 trailer.
// Revision : 1.0
// ============================================================================
module mfm_write_encoder #(
   parameter int HALF_CELL_CLKS = 8,
   parameter int PREAMBLE_BITS  = 47,
   parameter int POSTAMBLE_BITS = 16
) (
   input  wire logic           clk_in,
   input  wire logic           rst_in,
   input  wire logic           start,
   mfm_write_encoder_if.slave  wr,
   output logic                Drive_mfm_out,
   output logic                Drive_wg_out,
   output logic                busy,
   output logic                underrun
);

   localparam int c_clk_w    = $clog2(HALF_CELL_CLKS);
   localparam int c_bits_max = (PREAMBLE_BITS > POSTAMBLE_BITS)
                             ? ((PREAMBLE_BITS  > 16) ? PREAMBLE_BITS  : 16)
                             : ((POSTAMBLE_BITS > 16) ? POSTAMBLE_BITS : 16);
   localparam int c_bit_w    = $clog2(c_bits_max);

   localparam logic [c_clk_w-1:0] c_clk_last  = c_clk_w'(HALF_CELL_CLKS - 1);
   localparam logic [c_bit_w-1:0] c_pre_last  = c_bit_w'(PREAMBLE_BITS - 1);
   localparam logic [c_bit_w-1:0] c_post_last = c_bit_w'(POSTAMBLE_BITS - 1);
   localparam logic [c_bit_w-1:0] c_word_last = c_bit_w'(15);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PREAMBLE  = 3'd1,
      S_SYNC      = 3'd2,
      S_DATA      = 3'd3,
      S_CRC       = 3'd4,
      S_POSTAMBLE = 3'd5
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic [c_clk_w-1:0]   r_clk_cnt;
   logic                 r_half;
   logic [c_bit_w-1:0]   r_bit_cnt;
   logic                 r_prev;
   logic [15:0]          r_shift;
   logic [15:0]          r_buf;
   logic                 r_buf_full;
   logic                 r_buf_last;
   logic                 r_last_seen;
   logic                 r_underrun;

   logic                 w_cell_end;
   logic                 w_cur_bit;
   logic                 w_move;
   logic                 w_underrun_set;
   logic                 w_ready;
   logic                 w_accept;

`ifdef MFM_WRITE_CRC_EN
   logic [15:0]          r_crc;
   logic [15:0]          w_crc_next;
`endif

   assign w_cell_end = r_half & (r_clk_cnt == c_clk_last);

   always_comb begin
      w_cur_bit = 1'b0;
      case (r_state)
         S_SYNC:        w_cur_bit = 1'b1;
         S_DATA, S_CRC: w_cur_bit = r_shift[15];
         default:       w_cur_bit = 1'b0;
      endcase
   end

   // Holding buffer is only open in the front half of a frame, and never
   // after the word flagged last has been taken.
   always_comb begin
      w_ready = 1'b0;
      case (r_state)
         S_IDLE, S_PREAMBLE, S_SYNC, S_DATA:
            w_ready = ~r_buf_full & ~r_last_seen & ~rst_in;
         default: w_ready = 1'b0;
      endcase
   end

   assign wr.word_ready = w_ready;
   assign w_accept      = wr.word_valid & w_ready;

`ifdef MFM_WRITE_CRC_EN
   // CRC-16 (x^16+x^15+x^2+1), one data bit per cell, MSB-first order
   assign w_crc_next = {r_crc[14:0], 1'b0}
                     ^ ({16{r_crc[15] ^ w_cur_bit}} & 16'h8005);
`endif

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_move         = 1'b0;
      w_underrun_set = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_PREAMBLE;
            end
         end
         S_PREAMBLE: begin
            if (w_cell_end && (r_bit_cnt == c_pre_last)) begin
               w_state_next = S_SYNC;
            end
         end
         S_SYNC: begin
            if (w_cell_end) begin
               if (r_buf_full) begin
                  w_move       = 1'b1;
                  w_state_next = S_DATA;
               end else begin
                  w_underrun_set = 1'b1;
                  w_state_next   = S_POSTAMBLE;
               end
            end
         end
         S_DATA: begin
            if (w_cell_end && (r_bit_cnt == c_word_last)) begin
               if (r_last_seen) begin
`ifdef MFM_WRITE_CRC_EN
                  w_state_next = S_CRC;
`else
                  w_state_next = S_POSTAMBLE;
`endif
               end else if (r_buf_full) begin
                  w_move = 1'b1;
               end else begin
                  w_underrun_set = 1'b1;
                  w_state_next   = S_POSTAMBLE;
               end
            end
         end
`ifdef MFM_WRITE_CRC_EN
         S_CRC: begin
            if (w_cell_end && (r_bit_cnt == c_word_last)) begin
               w_state_next = S_POSTAMBLE;
            end
         end
`endif
         S_POSTAMBLE: begin
            if (w_cell_end && (r_bit_cnt == c_post_last)) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_clk_cnt   <= '0;
         r_half      <= 1'b0;
         r_bit_cnt   <= '0;
         r_prev      <= 1'b0;
         r_shift     <= '0;
         r_buf       <= '0;
         r_buf_full  <= 1'b0;
         r_buf_last  <= 1'b0;
         r_last_seen <= 1'b0;
         r_underrun  <= 1'b0;
      end else begin
         // Cell timing restarts on every state change so each state begins
         // on a fresh bit cell.
         if ((r_state != w_state_next) || (r_state == S_IDLE)) begin
            r_clk_cnt <= '0;
            r_half    <= 1'b0;
            r_bit_cnt <= '0;
         end else if (r_clk_cnt == c_clk_last) begin
            r_clk_cnt <= '0;
            r_half    <= ~r_half;
            if (r_half) begin
               r_bit_cnt <= ((r_state == S_DATA) && (r_bit_cnt == c_word_last))
                          ? '0 : r_bit_cnt + c_bit_w'(1);
            end
         end else begin
            r_clk_cnt <= r_clk_cnt + c_clk_w'(1);
         end

         if (r_state == S_IDLE) begin
            r_prev <= 1'b0;
         end else if (w_cell_end) begin
            r_prev <= w_cur_bit;
         end

         if (w_move) begin
            r_shift <= r_buf;
`ifdef MFM_WRITE_CRC_EN
         end else if ((r_state == S_DATA) && (w_state_next == S_CRC)) begin
            r_shift <= w_crc_next;
`endif
         end else if (w_cell_end && ((r_state == S_DATA) || (r_state == S_CRC))) begin
            r_shift <= {r_shift[14:0], 1'b0};
         end

         if (w_accept) begin
            r_buf      <= wr.word_in;
            r_buf_last <= wr.word_last;
            r_buf_full <= 1'b1;
         end else if (w_move) begin
            r_buf_full <= 1'b0;
         end

         if ((r_state == S_IDLE) || (w_state_next == S_IDLE)) begin
            r_last_seen <= 1'b0;
         end else if (w_move) begin
            r_last_seen <= r_buf_last;
         end

         if ((r_state == S_IDLE) && start) begin
            r_underrun <= 1'b0;
         end else if (w_underrun_set) begin
            r_underrun <= 1'b1;
         end
      end
   end

`ifdef MFM_WRITE_CRC_EN
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_crc <= '0;
      end else if (r_state == S_IDLE) begin
         r_crc <= '0;
      end else if ((r_state == S_DATA) && w_cell_end) begin
         r_crc <= w_crc_next;
      end
   end
`endif

   assign busy          = (r_state != S_IDLE);
   assign Drive_wg_out  = busy;
   assign underrun      = r_underrun;
   assign Drive_mfm_out = busy & (r_half ? w_cur_bit : (~w_cur_bit & ~r_prev));

endmodule
`default_nettype wire

// File: tb/tb_mfm_write_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mfm_write_encoder
// Summary  : Scoreboard bench for mfm_write_encoder; the expected half-cell
//            stream of each frame is built from the frame's bit list.
// Revision : 1.0
// ============================================================================
module tb_mfm_write_encoder;

   localparam int HALF = 8;
   localparam int PRE  = 47;
   localparam int POST = 16;

   logic clk_in;
   logic rst_in;
   logic start;
   logic Drive_mfm_out;
   logic Drive_wg_out;
   logic busy;
   logic underrun;

   mfm_write_encoder_if wif ();

   mfm_write_encoder #(
      .HALF_CELL_CLKS (HALF),
      .PREAMBLE_BITS  (PRE),
      .POSTAMBLE_BITS (POST)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start         (start),
      .wr            (wif.slave),
      .Drive_mfm_out (Drive_mfm_out),
      .Drive_wg_out  (Drive_wg_out),
      .busy          (busy),
      .underrun      (underrun)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          exp_half[$];
   int          exp_len[$];
   bit          exp_unr[$];
   logic [15:0] frame_words[$];
   bit          mon_active = 1'b0;
   int          mon_cyc    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired or scoreboard empty at %0t", name, $time);
   endtask

   // Remainder of M(x)*x^16 divided by x^16+x^15+x^2+1, by long division.
   function automatic logic [15:0] crc_model(input bit msg[$]);
      bit          a[$];
      logic [16:0] poly = 17'h18005;
      logic [15:0] rem  = '0;
      a = msg;
      for (int i = 0; i < 16; i++) a.push_back(1'b0);
      for (int i = 0; i + 16 < a.size(); i++) begin
         if (a[i]) begin
            for (int j = 0; j <= 16; j++) a[i+j] = a[i+j] ^ poly[16-j];
         end
      end
      for (int i = 0; i < 16; i++) rem[15-i] = a[a.size()-16+i];
      return rem;
   endfunction

   task automatic expect_frame(input bit has_last);
      bit          bits[$];
      bit          data[$];
      bit          prev;
      logic [15:0] w;
      for (int i = 0; i < frame_words.size(); i++) begin
         w = frame_words[i];
         for (int b = 15; b >= 0; b--) data.push_back(w[b]);
      end
      for (int i = 0; i < PRE; i++) bits.push_back(1'b0);
      bits.push_back(1'b1);
      for (int i = 0; i < data.size(); i++) bits.push_back(data[i]);
`ifdef MFM_WRITE_CRC_EN
      if (has_last) begin
         w = crc_model(data);
         for (int b = 15; b >= 0; b--) bits.push_back(w[b]);
      end
`endif
      for (int i = 0; i < POST; i++) bits.push_back(1'b0);
      prev = 1'b0;
      for (int i = 0; i < bits.size(); i++) begin
         exp_half.push_back(!bits[i] && !prev);
         exp_half.push_back(bits[i]);
         prev = bits[i];
      end
      exp_len.push_back(bits.size() * 2 * HALF);
      exp_unr.push_back(!has_last);
   endtask

   // Monitor: compares every in-frame cycle against the head half-cell.
   always @(negedge clk_in) begin
      if (rst_in) begin
         mon_active = 1'b0;
      end else begin
         chk("busy_vs_wg", {31'd0, busy}, {31'd0, Drive_wg_out});
         if (Drive_wg_out) begin
            if (!mon_active) begin
               mon_active = 1'b1;
               mon_cyc    = 0;
            end
            if (exp_half.size() == 0) fail_now("mfm_extra_cycle");
            else chk("mfm_level", {31'd0, Drive_mfm_out}, {31'd0, exp_half[0]});
            mon_cyc++;
            if ((mon_cyc % HALF == 0) && (exp_half.size() > 0)) void'(exp_half.pop_front());
         end else begin
            chk("idle_mfm", {31'd0, Drive_mfm_out}, 32'd0);
            if (mon_active) begin
               mon_active = 1'b0;
               if (exp_len.size() == 0) fail_now("frame_len_missing");
               else chk("frame_len", mon_cyc, exp_len.pop_front());
               if (exp_unr.size() == 0) fail_now("frame_unr_missing");
               else chk("frame_underrun", {31'd0, underrun}, {31'd0, exp_unr.pop_front()});
               chk("half_cells_left", exp_half.size(), 32'd0);
            end
         end
      end
   end

   task automatic push_word(input logic [15:0] w, input bit last);
      bit done = 1'b0;
      wif.word_in    = w;
      wif.word_last  = last;
      wif.word_valid = 1'b1;
      for (int i = 0; i < 6000 && !done; i++) begin
         @(negedge clk_in);
         if (wif.word_ready) begin
            @(posedge clk_in);
            #1;
            done = 1'b1;
         end
      end
      wif.word_valid = 1'b0;
      if (!done) fail_now("word_ready_timeout");
   endtask

   task automatic pulse_start();
      @(posedge clk_in);
      #1 start = 1'b1;
      @(posedge clk_in);
      #1 start = 1'b0;
      chk("start_busy", {31'd0, busy}, 32'd1);
      chk("start_underrun_clr", {31'd0, underrun}, 32'd0);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 6000 && !done; i++) begin
         @(negedge clk_in);
         if (!busy) done = 1'b1;
      end
      if (!done) fail_now("frame_end_timeout");
      repeat (4) @(posedge clk_in);
      #1;
   endtask

   task automatic run_frame(input bit has_last, input int max_gap);
      int nw = frame_words.size();
      expect_frame(has_last);
      push_word(frame_words[0], has_last && (nw == 1));
      pulse_start();
      for (int i = 1; i < nw; i++) begin
         repeat ($urandom_range(0, max_gap)) @(posedge clk_in);
         #1;
         push_word(frame_words[i], has_last && (i == nw - 1));
      end
      wait_idle();
   endtask

   initial begin
      rst_in         = 1'b1;
      start          = 1'b0;
      wif.word_in    = '0;
      wif.word_valid = 1'b0;
      wif.word_last  = 1'b0;

      #12;
      chk("rst_mfm",   {31'd0, Drive_mfm_out}, 32'd0);
      chk("rst_wg",    {31'd0, Drive_wg_out},  32'd0);
      chk("rst_busy",  {31'd0, busy},          32'd0);
      chk("rst_ready", {31'd0, wif.word_ready}, 32'd0);
      chk("rst_unr",   {31'd0, underrun},      32'd0);
      #20 rst_in = 1'b0;

      repeat (100) @(posedge clk_in);
      #1;
      chk("idle_wg",    {31'd0, Drive_wg_out},   32'd0);
      chk("idle_busy",  {31'd0, busy},           32'd0);
      chk("idle_ready", {31'd0, wif.word_ready}, 32'd1);

      frame_words = '{16'h0000};
      run_frame(1'b1, 0);

      frame_words = '{16'hA5F0};
      run_frame(1'b1, 0);

      frame_words = '{16'h1234, 16'h5678, 16'h9ABC};
      run_frame(1'b1, 0);
      chk("three_word_unr", {31'd0, underrun}, 32'd0);

      for (int f = 0; f < 3; f++) begin
         frame_words.delete();
         for (int i = 0; i < int'($urandom_range(1, 4)); i++)
            frame_words.push_back(16'($urandom));
         run_frame(1'b1, 30);
      end

`ifdef MFM_WRITE_CRC_EN
      frame_words = '{16'h0001};
      run_frame(1'b1, 0);
`endif

      // Word without last and nothing behind it.
      frame_words = '{16'($urandom)};
      run_frame(1'b0, 0);
      repeat (50) @(posedge clk_in);
      #1;
      chk("underrun_sticky", {31'd0, underrun}, 32'd1);
      chk("underrun_idle_ready", {31'd0, wif.word_ready}, 32'd1);

      // Reset in the middle of the data phase.
      frame_words = '{16'($urandom), 16'($urandom)};
      expect_frame(1'b1);
      push_word(frame_words[0], 1'b0);
      pulse_start();
      repeat ((PRE + 1 + 4) * 2 * HALF) @(posedge clk_in);
      #3 rst_in = 1'b1;
      #1;
      chk("midrst_mfm",   {31'd0, Drive_mfm_out},  32'd0);
      chk("midrst_wg",    {31'd0, Drive_wg_out},   32'd0);
      chk("midrst_busy",  {31'd0, busy},           32'd0);
      chk("midrst_ready", {31'd0, wif.word_ready}, 32'd0);
      chk("midrst_unr",   {31'd0, underrun},       32'd0);
      exp_half.delete();
      exp_len.delete();
      exp_unr.delete();
      repeat (3) @(posedge clk_in);
      #3 rst_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      chk("postrst_ready", {31'd0, wif.word_ready}, 32'd1);
      chk("postrst_busy",  {31'd0, busy},           32'd0);

      frame_words = '{16'($urandom), 16'($urandom)};
      run_frame(1'b1, 30);

      chk("final_queue_empty", exp_len.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
